sdram_port_arbiter: RTL and testbench
=====================================

// Module: sdram_port_arbiter
// PURPOSE
//  Shares one 32-bit sdram_controller_16_to_32 CPU-side port between three requesters:
//  p0 = read-only video/DMA fetch (priority), p1 = CPU instruction, p2 = CPU data (r/w).
//  Sits between the requesters and the SDRAM controller; uses the same level req/ack
//  handshake on both sides. One transaction in flight at a time.
// PARAMETERS
//  ADDRESS_WIDTH  23  word address width (bank+row+column-1), same on all ports
//  P0_MAX_BURST   4   max consecutive p0 grants while p1/p2 pending (1..15)
// PORTS
//  clk          in   1   clock
//  nreset       in   1   synchronous active-low reset
//  p0_req       in   1   p0 request (level, held until p0_ack)
//  p0_address   in   AW  p0 word address
//  p0_data_out  out  32  p0 read data, valid while p0_ack=1
//  p0_ack       out  1   p0 done; held until p0_req low
//  p1_req/p1_address/p1_data_out/p1_ack   as p0
//  p2_req/p2_address/p2_data_out/p2_ack   as p0
//  p2_data_in   in   32  p2 write data
//  p2_nwr       in   4   p2 active-low byte write enables; 4'hF = read
//  mem_req      out  1   to controller cpu_req
//  mem_address  out  AW  to controller cpu_address
//  mem_data_out out  32  to controller cpu_data_in
//  mem_nwr      out  4   to controller cpu_nwr (p0/p1 always 4'hF)
//  mem_data_in  in   32  from controller cpu_data_out
//  mem_ack      in   1   from controller cpu_ack
// BEHAVIOUR
//  Reset: all pX_ack=0, pX_data_out=0, mem_req=0, mem_address=0, mem_data_out=0,
//   mem_nwr=4'hF, state=IDLE, streak=0, rr=p1. Reset mid-transaction abandons it
//   (controller shares nreset); no ack is issued for it.
//  Eligible(x) = pX_req & !pX_ack.
//  States:
//   IDLE: if any eligible, pick winner; register address/data/nwr of winner onto
//    mem_*, grant<=winner, mem_req<=1 -> BUSY. mem_req rises 1 cycle after pX_req.
//   BUSY: mem_* held stable. On mem_ack=1: mem_req<=0, pgrant_data_out<=mem_data_in,
//    pgrant_ack<=1 -> RELEASE.
//   RELEASE: wait mem_ack=0 (controller clears it in its idle state) -> IDLE.
//  Ack release: any pX_ack with pX_req=0 clears on next edge, independent of state.
//  Selection: p0 wins if eligible and (streak<P0_MAX_BURST or no p1/p2 eligible).
//   Else round-robin p1/p2: if both eligible, grant the one != rr; single eligible wins.
//   p0 grant: streak<=streak+1 (saturating). p1/p2 grant: streak<=0, rr<=granted port.
//  Port requests sampled only in IDLE; address/data changes during BUSY ignored.
//  Requester dropping req during BUSY: transaction completes, ack pulses 1 cycle,
//   data register still updated.
//  Minimum back-to-back turnaround: IDLE->BUSY->RELEASE->IDLE; a new grant is
//   never issued while mem_ack=1.
//  pX_data_out only changes on completion of that port's transaction.
// TESTING
//  Single p1 read, controller model acks 6 cycles after mem_req with 32'hDEADBEEF ->
//   mem_req 1 cycle after p1_req, p1_ack=1, p1_data_out=32'hDEADBEEF, mem_nwr=4'hF.
//  p2 write addr 0x12345, data 32'hA5A55A5A, nwr 4'b1100 -> mem_* carry exactly those
//   values stable across BUSY; p2_ack only after mem_ack; p2_data_out updated.
//  p0,p1,p2 held continuously, P0_MAX_BURST=4 -> grant order p0,p0,p0,p0,p1,p0,p0,p0,p0,p2.
//  p1 and p2 only, both held -> strict alternation p1,p2,p1,p2.
//  p1_req dropped while BUSY -> transaction completes, p1_ack high one cycle then 0.
//  nreset asserted in BUSY -> next cycle mem_req=0, all acks 0, state IDLE, streak 0.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// Three-port arbiter onto one SDRAM controller CPU port: p0 priority with burst cap, p1/p2 round-robin.
// Latency: mem_req one cycle after an eligible request is seen in IDLE; port ack one cycle after mem_ack.
// Backpressure: level req/ack on both sides; one transaction in flight, new grants wait for mem_ack low.
module sdram_port_arbiter #(
    parameter int ADDRESS_WIDTH = 23,
    parameter int P0_MAX_BURST  = 4
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     p0_req,
    input  logic [ADDRESS_WIDTH-1:0] p0_address,
    output logic [31:0]              p0_data_out,
    output logic                     p0_ack,
    input  logic                     p1_req,
    input  logic [ADDRESS_WIDTH-1:0] p1_address,
    output logic [31:0]              p1_data_out,
    output logic                     p1_ack,
    input  logic                     p2_req,
    input  logic [ADDRESS_WIDTH-1:0] p2_address,
    output logic [31:0]              p2_data_out,
    output logic                     p2_ack,
    input  logic [31:0]              p2_data_in,
    input  logic [3:0]               p2_nwr,
    output logic                     mem_req,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [31:0]              mem_data_out,
    output logic [3:0]               mem_nwr,
    input  logic [31:0]              mem_data_in,
    input  logic                     mem_ack
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [3:0] P0_MAX     = 4'(P0_MAX_BURST);

    logic [1:0]               state_q, state_d;
    logic [1:0]               grant_q, grant_d;
    logic [3:0]               streak_q, streak_d;
    logic                     rr_q, rr_d;           // last round-robin winner: 0 = p1, 1 = p2
    logic                     mem_req_q, mem_req_d;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]              mem_dat_q, mem_dat_d;
    logic [3:0]               mem_nwr_q, mem_nwr_d;
    logic [2:0]               ack_q, ack_d;
    logic [2:0][31:0]         dout_q, dout_d;

    logic [2:0]               req;
    logic [2:0]               elig;
    logic [1:0]               win;
    logic [ADDRESS_WIDTH-1:0] win_addr;

    assign req  = {p2_req, p1_req, p0_req};
    assign elig = req & ~ack_q;

    // Pick the winner among eligible ports: p0 first unless its streak is exhausted while others wait.
    always_comb begin
        win = 2'd0;
        if (elig[0] && ((streak_q < P0_MAX) || !(elig[1] || elig[2]))) begin
            win = 2'd0;
        end else if (elig[1] && elig[2]) begin
            win = rr_q ? 2'd1 : 2'd2;
        end else if (elig[1]) begin
            win = 2'd1;
        end else if (elig[2]) begin
            win = 2'd2;
        end
        case (win)
            2'd1:    win_addr = p1_address;
            2'd2:    win_addr = p2_address;
            default: win_addr = p0_address;
        endcase
    end

    // Next-state: grant in IDLE, complete in BUSY, wait for the controller to drop mem_ack in RELEASE.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        streak_d   = streak_q;
        rr_d       = rr_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        mem_dat_d  = mem_dat_q;
        mem_nwr_d  = mem_nwr_q;
        dout_d     = dout_q;
        // an ack falls as soon as its requester has let go, whatever the state
        ack_d      = ack_q & req;
        case (state_q)
            ST_IDLE: begin
                if ((elig != 3'b000) && !mem_ack) begin
                    grant_d    = win;
                    mem_req_d  = 1'b1;
                    mem_addr_d = win_addr;
                    mem_dat_d  = (win == 2'd2) ? p2_data_in : 32'h0;
                    mem_nwr_d  = (win == 2'd2) ? p2_nwr : 4'hF;
                    state_d    = ST_BUSY;
                    if (win == 2'd0) begin
                        if (streak_q != 4'hF) streak_d = streak_q + 4'd1;
                    end else begin
                        streak_d = 4'd0;
                        rr_d     = (win == 2'd2);
                    end
                end
            end
            ST_BUSY: begin
                if (mem_ack) begin
                    mem_req_d       = 1'b0;
                    dout_d[grant_q] = mem_data_in;
                    ack_d[grant_q]  = 1'b1;
                    state_d         = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!mem_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset abandons any transaction in flight without acking it.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q    <= ST_IDLE;
            grant_q    <= 2'd0;
            streak_q   <= 4'd0;
            rr_q       <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_dat_q  <= 32'h0;
            mem_nwr_q  <= 4'hF;
            ack_q      <= 3'b000;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            streak_q   <= streak_d;
            rr_q       <= rr_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            mem_dat_q  <= mem_dat_d;
            mem_nwr_q  <= mem_nwr_d;
            ack_q      <= ack_d;
            dout_q     <= dout_d;
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_address  = mem_addr_q;
    assign mem_data_out = mem_dat_q;
    assign mem_nwr      = mem_nwr_q;
    assign p0_ack       = ack_q[0];
    assign p1_ack       = ack_q[1];
    assign p2_ack       = ack_q[2];
    assign p0_data_out  = dout_q[0];
    assign p1_data_out  = dout_q[1];
    assign p2_data_out  = dout_q[2];

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: requester and controller models, transaction-level reference model.
// Inputs change 1 time unit after posedge; outputs are compared on the negedge.
// Requesters follow the level req/ack protocol; every wait is bounded.
module tb_sdram_port_arbiter;
    localparam int AW   = 23;
    localparam int MAXB = 4;

    logic          clk = 1'b0;
    logic          nreset;
    logic [2:0]    req;
    logic [AW-1:0] addr [3];
    logic [31:0]   dout [3];
    logic [2:0]    ack;
    logic [31:0]   p2_din;
    logic [3:0]    p2_nwr;
    logic          mem_req;
    logic [AW-1:0] mem_address;
    logic [31:0]   mem_data_out;
    logic [3:0]    mem_nwr;
    logic [31:0]   mem_data_in;
    logic          mem_ack;

    int vectors     = 0;
    int miscompares = 0;

    sdram_port_arbiter #(.ADDRESS_WIDTH(AW), .P0_MAX_BURST(MAXB)) dut (
        .clk(clk), .nreset(nreset),
        .p0_req(req[0]), .p0_address(addr[0]), .p0_data_out(dout[0]), .p0_ack(ack[0]),
        .p1_req(req[1]), .p1_address(addr[1]), .p1_data_out(dout[1]), .p1_ack(ack[1]),
        .p2_req(req[2]), .p2_address(addr[2]), .p2_data_out(dout[2]), .p2_ack(ack[2]),
        .p2_data_in(p2_din), .p2_nwr(p2_nwr),
        .mem_req(mem_req), .mem_address(mem_address), .mem_data_out(mem_data_out),
        .mem_nwr(mem_nwr), .mem_data_in(mem_data_in), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Controller model: acks a held mem_req after a latency, drops ack once mem_req is gone.
    int          ctrl_lat_fixed  = 0;
    bit          ctrl_use_fixed  = 1'b0;
    logic [31:0] ctrl_data_fixed = 32'h0;
    int          ctrl_cnt        = 0;
    int          ctrl_lat        = 1;
    always @(posedge clk) begin
        #1;
        if (!nreset) begin
            mem_ack  = 1'b0;
            ctrl_cnt = 0;
        end else if (mem_req && !mem_ack) begin
            if (ctrl_cnt == 0) ctrl_lat = (ctrl_lat_fixed != 0) ? ctrl_lat_fixed : int'($urandom_range(1, 6));
            ctrl_cnt++;
            if (ctrl_cnt >= ctrl_lat) begin
                mem_ack     = 1'b1;
                mem_data_in = ctrl_use_fixed ? ctrl_data_fixed : $urandom;
                ctrl_cnt    = 0;
            end
        end else if (!mem_req && mem_ack) begin
            mem_ack = 1'b0;
        end
    end

    // Reference model state (transaction level) and the input snapshot the DUT sees at the next edge.
    int            m_phase, m_streak, m_rr, m_grant;
    logic          m_req;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_dat;
    logic [3:0]    m_nwr;
    logic [2:0]    m_ack;
    logic [31:0]   m_dout [3];
    bit            s_valid = 1'b0;
    logic          s_nreset, s_mack;
    logic [2:0]    s_req;
    logic [AW-1:0] s_addr [3];
    logic [31:0]   s_din, s_mdin;
    logic [3:0]    s_nwr;
    int            glog [$];
    logic [2:0]    prev_ack_obs = 3'b000;

    always @(negedge clk) begin : cmp
        logic [2:0] el;
        logic [2:0] na;
        int         w;
        if (s_valid) begin
            if (!s_nreset) begin
                m_phase = 0; m_streak = 0; m_rr = 1; m_grant = 0;
                m_req = 1'b0; m_addr = '0; m_dat = 32'h0; m_nwr = 4'hF; m_ack = 3'b000;
                for (int i = 0; i < 3; i++) m_dout[i] = 32'h0;
            end else begin
                na = m_ack & s_req;
                if (m_phase == 0) begin
                    el = s_req & ~m_ack;
                    if (el != 3'b000 && !s_mack) begin
                        if (el[0] && (m_streak < MAXB || el[2:1] == 2'b00)) w = 0;
                        else if (el[1] && el[2]) w = (m_rr == 1) ? 2 : 1;
                        else w = el[1] ? 1 : 2;
                        if (w == 0) m_streak = (m_streak >= 15) ? 15 : m_streak + 1;
                        else begin
                            m_streak = 0;
                            m_rr     = w;
                        end
                        m_grant = w;
                        m_addr  = s_addr[w];
                        m_dat   = (w == 2) ? s_din : 32'h0;
                        m_nwr   = (w == 2) ? s_nwr : 4'hF;
                        m_req   = 1'b1;
                        m_phase = 1;
                    end
                end else if (m_phase == 1) begin
                    if (s_mack) begin
                        m_req           = 1'b0;
                        m_dout[m_grant] = s_mdin;
                        na[m_grant]     = 1'b1;
                        m_phase         = 2;
                    end
                end else if (!s_mack) begin
                    m_phase = 0;
                end
                m_ack = na;
            end
            chk("mem_req", mem_req, m_req);
            chk("mem_address", mem_address, m_addr);
            chk("mem_data_out", mem_data_out, m_dat);
            chk("mem_nwr", mem_nwr, m_nwr);
            chk("acks", ack, m_ack);
            for (int i = 0; i < 3; i++) chk($sformatf("p%0d_data_out", i), dout[i], m_dout[i]);
        end
        for (int i = 0; i < 3; i++) if (ack[i] && !prev_ack_obs[i]) glog.push_back(i);
        prev_ack_obs = ack;
        s_nreset = nreset; s_req = req; s_addr = addr; s_din = p2_din; s_nwr = p2_nwr;
        s_mack = mem_ack; s_mdin = mem_data_in;
        s_valid = 1'b1;
    end

    // One requester issuing n transactions, with optional random idle gaps between them.
    task automatic run_port(input int p, input int n, input int maxgap);
        for (int k = 0; k < n; k++) begin
            int t;
            if (maxgap > 0) cyc($urandom_range(0, maxgap));
            t = 0;
            while (ack[p] && t < 100) begin cyc(1); t++; end
            chk($sformatf("p%0d_ack_release_timeout", p), ack[p], 1'b0);
            req[p]  = 1'b1;
            addr[p] = AW'($urandom);
            if (p == 2) begin
                p2_din = $urandom;
                p2_nwr = 4'($urandom);
            end
            t = 0;
            while (!ack[p] && t < 400) begin cyc(1); t++; end
            chk($sformatf("p%0d_ack_timeout", p), ack[p], 1'b1);
            req[p] = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int exp3 [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2};
        int exp4 [4]  = '{1, 2, 1, 2};
        nreset = 1'b0; req = 3'b000; p2_din = 32'h0; p2_nwr = 4'hF;
        for (int i = 0; i < 3; i++) addr[i] = '0;
        mem_data_in = 32'h0; mem_ack = 1'b0;
        cyc(3);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_nwr", mem_nwr, 4'hF);
        chk("rst_acks", ack, 3'b000);
        chk("rst_p1_data", dout[1], 32'h0);
        nreset = 1'b1;
        cyc(2);

        // single p1 read, fixed latency and data
        ctrl_lat_fixed = 6; ctrl_use_fixed = 1'b1; ctrl_data_fixed = 32'hDEADBEEF;
        addr[1] = 23'h0ABCD; req[1] = 1'b1;
        cyc(1);
        chk("t1_mem_req_1cyc", mem_req, 1'b1);
        chk("t1_mem_nwr", mem_nwr, 4'hF);
        chk("t1_mem_address", mem_address, 23'h0ABCD);
        n = 0;
        while (!ack[1] && n < 50) begin cyc(1); n++; end
        chk("t1_ack_latency", n, 6);
        chk("t1_p1_data", dout[1], 32'hDEADBEEF);
        req[1] = 1'b0;
        cyc(1);
        chk("t1_ack_drop", ack[1], 1'b0);
        cyc(3);

        // p2 write; its inputs are scrambled after the grant and must not leak through
        ctrl_data_fixed = 32'h0F1E2D3C;
        addr[2] = 23'h12345; p2_din = 32'hA5A55A5A; p2_nwr = 4'b1100; req[2] = 1'b1;
        cyc(1);
        addr[2] = 23'h7FFFFF; p2_din = 32'h0; p2_nwr = 4'hF;
        n = 0;
        while (!ack[2] && n < 50) begin
            chk("t2_addr_stable", mem_address, 23'h12345);
            chk("t2_data_stable", mem_data_out, 32'hA5A55A5A);
            chk("t2_nwr_stable", mem_nwr, 4'b1100);
            cyc(1);
            n++;
        end
        chk("t2_ack_latency", n, 6);
        chk("t2_p2_data", dout[2], 32'h0F1E2D3C);
        req[2] = 1'b0;
        ctrl_lat_fixed = 0; ctrl_use_fixed = 1'b0;
        cyc(4);

        // all three held: p0 burst cap then round-robin
        glog.delete();
        fork
            run_port(0, 9, 0);
            run_port(1, 2, 0);
            run_port(2, 2, 0);
        join
        cyc(3);
        chk("t3_grant_count", glog.size(), 13);
        for (int k = 0; k < 10; k++) chk($sformatf("t3_grant%0d", k), (k < glog.size()) ? glog[k] : 99, exp3[k]);

        // p1 and p2 only: strict alternation
        glog.delete();
        fork
            run_port(1, 2, 0);
            run_port(2, 2, 0);
        join
        cyc(3);
        for (int k = 0; k < 4; k++) chk($sformatf("t4_grant%0d", k), (k < glog.size()) ? glog[k] : 99, exp4[k]);

        // p1 drops req while busy: completes, ack pulses a single cycle
        ctrl_lat_fixed = 5;
        addr[1] = 23'h00F00; req[1] = 1'b1;
        cyc(2);
        req[1] = 1'b0;
        n = 0;
        while (!ack[1] && n < 50) begin cyc(1); n++; end
        chk("t5_ack_pulse", ack[1], 1'b1);
        cyc(1);
        chk("t5_ack_clear", ack[1], 1'b0);
        cyc(4);

        // reset while busy
        ctrl_lat_fixed = 6;
        addr[0] = 23'h00555; req[0] = 1'b1;
        cyc(2);
        chk("t6_busy", mem_req, 1'b1);
        nreset = 1'b0;
        cyc(1);
        chk("t6_rst_mem_req", mem_req, 1'b0);
        chk("t6_rst_acks", ack, 3'b000);
        chk("t6_rst_mem_nwr", mem_nwr, 4'hF);
        cyc(1);
        nreset = 1'b1;
        cyc(1);
        chk("t6_regrant", mem_req, 1'b1);
        n = 0;
        while (!ack[0] && n < 50) begin cyc(1); n++; end
        chk("t6_ack", ack[0], 1'b1);
        req[0] = 1'b0;
        ctrl_lat_fixed = 0;
        cyc(4);

        // randomized traffic on all ports
        for (int r = 0; r < 4; r++) begin
            fork
                run_port(0, $urandom_range(5, 15), 3);
                run_port(1, $urandom_range(5, 15), 3);
                run_port(2, $urandom_range(5, 15), 3);
            join
            cyc($urandom_range(1, 5));
        end
        cyc(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
